// File: rtl/word_assembler_pkg.sv
// Shared helpers for the word assembler.
//   lane_w(ratio)              : width of a lane/beat counter for RATIO lanes
//   pos(k, ratio, msb_first)   : output lane position of beat k within a word
package word_assembler_pkg;

  function automatic int unsigned lane_w(input int unsigned ratio);
    return (ratio > 1) ? $clog2(ratio) : 1;
  endfunction

  function automatic int unsigned pos(input int unsigned k,
                                      input int unsigned ratio,
                                      input bit          msb_first);
    return msb_first ? (ratio - 1 - k) : k;
  endfunction

endpackage

// File: rtl/word_assembler_outreg.sv
// Output holding register with valid/ready handshake.
//   clk, rst    : falling-edge clock, async active-low reset
//   load        : capture load_data/load_keep and raise out_valid
//   load_data   : word to present
//   load_keep   : per-lane keep flags for the word
//   out_valid   : word held and valid
//   out_data    : held word
//   out_keep    : held keep flags
//   out_ready   : consumer accepts the held word
module word_assembler_outreg #(
  parameter int unsigned DATA_W = 32,
  parameter int unsigned KEEP_W = 4
) (
  input  logic              clk,
  input  logic              rst,
  input  logic              load,
  input  logic [DATA_W-1:0] load_data,
  input  logic [KEEP_W-1:0] load_keep,
  output logic              out_valid,
  output logic [DATA_W-1:0] out_data,
  output logic [KEEP_W-1:0] out_keep,
  input  logic              out_ready
);

  always_ff @(negedge clk or negedge rst) begin
    if (!rst) begin
      out_valid <= 1'b0;
      out_data  <= '0;
      out_keep  <= '0;
    end else if (load) begin
      out_valid <= 1'b1;
      out_data  <= load_data;
      out_keep  <= load_keep;
    end else if (out_ready) begin
      out_valid <= 1'b0;
    end
  end

endmodule

// File: rtl/word_assembler.sv
// Narrow-to-wide packer: collects RATIO beats of IN_W bits into one word.
//   clk, rst    : falling-edge clock, async active-low reset
//   in_valid    : in_data valid
//   in_data     : input beat
//   in_ready    : a beat can be accepted this cycle
//   flush       : level request to emit the current partial word
//   flush_done  : one-cycle pulse when a flush is taken
//   out_valid   : out_data/out_keep valid
//   out_data    : assembled word (IN_W*RATIO bits)
//   out_keep    : keep[j]=1 when lane j holds a received beat
//   out_ready   : consumer accepts the word
module word_assembler
  import word_assembler_pkg::*;
#(
  parameter int unsigned IN_W      = 8,
  parameter int unsigned RATIO     = 4,
  parameter bit          MSB_FIRST = 1'b1
) (
  input  logic                  clk,
  input  logic                  rst,
  input  logic                  in_valid,
  input  logic [IN_W-1:0]       in_data,
  output logic                  in_ready,
  input  logic                  flush,
  output logic                  flush_done,
  output logic                  out_valid,
  output logic [IN_W*RATIO-1:0] out_data,
  output logic [RATIO-1:0]      out_keep,
  input  logic                  out_ready
);

  localparam int unsigned OUT_W = IN_W * RATIO;
  localparam int unsigned CW    = lane_w(RATIO);
  localparam logic [CW-1:0] LAST = CW'(RATIO - 1);

  // Lanes are stored in arrival order; the position mapping is applied
  // only when the output word is built.
  logic [IN_W-1:0]  lanes [0:RATIO-2];
  logic [CW-1:0]    cnt;

  logic             slot_free;
  logic             accept;
  logic             complete;
  logic             flush_take;
  logic             load;
  logic [OUT_W-1:0] word_d;
  logic [RATIO-1:0] keep_d;

  assign slot_free  = !out_valid || out_ready;
  assign in_ready   = (flush && !slot_free) ? 1'b0 : ((cnt != LAST) || slot_free);
  assign accept     = in_valid && in_ready;
  assign complete   = accept && (cnt == LAST);
  assign flush_take = flush && slot_free;
  assign load       = complete || (flush_take && ((cnt != '0) || accept));

  // Word = held lanes plus the beat accepted this cycle; lanes beyond the
  // resulting count stay zero with keep cleared.
  always_comb begin
    word_d = '0;
    keep_d = '0;
    for (int unsigned k = 0; k < RATIO - 1; k++) begin
      if (CW'(k) < cnt) begin
        word_d[pos(k, RATIO, MSB_FIRST)*IN_W +: IN_W] = lanes[k];
        keep_d[pos(k, RATIO, MSB_FIRST)]              = 1'b1;
      end else if ((CW'(k) == cnt) && accept) begin
        word_d[pos(k, RATIO, MSB_FIRST)*IN_W +: IN_W] = in_data;
        keep_d[pos(k, RATIO, MSB_FIRST)]              = 1'b1;
      end
    end
    if (complete) begin
      word_d[pos(RATIO - 1, RATIO, MSB_FIRST)*IN_W +: IN_W] = in_data;
      keep_d[pos(RATIO - 1, RATIO, MSB_FIRST)]              = 1'b1;
    end
  end

  always_ff @(negedge clk or negedge rst) begin
    if (!rst) begin
      cnt        <= '0;
      flush_done <= 1'b0;
      for (int unsigned k = 0; k < RATIO - 1; k++) begin
        lanes[k] <= '0;
      end
    end else begin
      flush_done <= flush_take;
      if (complete || flush_take) begin
        cnt <= '0;
      end else if (accept) begin
        lanes[cnt] <= in_data;
        cnt        <= cnt + CW'(1);
      end
    end
  end

  word_assembler_outreg #(
    .DATA_W (OUT_W),
    .KEEP_W (RATIO)
  ) u_outreg (
    .clk       (clk),
    .rst       (rst),
    .load      (load),
    .load_data (word_d),
    .load_keep (keep_d),
    .out_valid (out_valid),
    .out_data  (out_data),
    .out_keep  (out_keep),
    .out_ready (out_ready)
  );

endmodule

// File: doc/word_assembler.md
Name: word_assembler

Overview:
Parametrised narrow-to-wide packer for the datapath input side. It collects RATIO beats of IN_W bits into one OUT_W = IN_W*RATIO word, with selectable lane order. It uses a valid/ready handshake on both sides, per-lane keep flags, and a flush that emits a zero-padded partial word. It sits between the external byte stream and the instruction/data load path.

Parameters:
IN_W, 8, input beat width in bits (>=1)
RATIO, 4, beats per output word (>=2); OUT_W = IN_W*RATIO
MSB_FIRST, 1, 1: first beat lands in the most-significant lane; 0: first beat lands in the least-significant lane

Ports:
clk  in  1  clock; all registers update on the falling edge of clk
rst  in  1  asynchronous, active-low reset
in_valid  in  1  in_data is valid this cycle
in_data  in  IN_W  input beat
in_ready  out  1  block can accept a beat this cycle
flush  in  1  level request: emit the current partial word
flush_done  out  1  one-cycle pulse when a flush has been taken
out_valid  out  1  out_data/out_keep valid
out_data  out  OUT_W  assembled word
out_keep  out  RATIO  keep[j]=1 when out_data[j*IN_W +: IN_W] holds a received beat
out_ready  in  1  consumer accepts the word

Behaviour:
- Reset (async, rst=0): cnt=0, out_valid=0, out_data=0, out_keep=0, flush_done=0, internal lane buffer cleared. A partial word in progress is discarded with no output.
- State:
  - cnt, range 0..RATIO-1: number of lanes already held in the buffer (lanes 0..RATIO-2).
  - One output register.
- slot_free = !out_valid || out_ready.
- Lane mapping: beat number k (0-based within the word) goes to position p = MSB_FIRST ? RATIO-1-k : k, i.e. out_data[p*IN_W +: IN_W]. The keep bit for that beat is out_keep[p].
- Accept: a beat is accepted at a falling edge when in_valid && in_ready.
- in_ready = 0 while flush=1 && !slot_free. Otherwise in_ready = (cnt != RATIO-1) || slot_free.
- Accepted beat with cnt < RATIO-1 and no flush taken: store the beat in lane cnt, cnt <= cnt+1.
- Accepted beat with cnt == RATIO-1 (word completes):
  - Output register <= buffer plus this beat, all keep bits = 1.
  - out_valid=1 after that same edge (zero-cycle latency from the last beat). cnt <= 0.
- Flush taken when flush && slot_free at an edge:
  - If a beat is accepted in the same cycle, it is included first.
  - If the resulting lane count is >0, emit the word: unfilled lanes are 0 and their keep bits 0.
  - cnt <= 0 and flush_done pulses for one cycle.
  - If the lane count is 0 (empty, no beat this cycle), no word is emitted; flush_done still pulses.
  - If the accepted beat completes a full word in the same cycle, the emitted word is full (keep all 1) and it is also the flush.
- flush && !slot_free: flush is not taken, in_ready=0, flush_done=0. The requester holds flush until it sees flush_done.
- Output drain: out_valid && out_ready clears out_valid at the edge, unless a new word is loaded at the same edge, in which case out_valid stays 1 with the new contents. out_data/out_keep hold stable while out_valid && !out_ready.
- Throughput: one beat per cycle sustained when out_ready=1. Back-to-back words have no bubble.
- flush_done deasserts the cycle after its pulse even if flush stays high. A flush held high continues to be taken each slot-free cycle; an empty buffer produces no words.

Decomposition:
- Shared package: lane-index width function (clog2 of RATIO) and the lane-position mapping helper pos(k, MSB_FIRST).
- One sub-module is natural: word_assembler_outreg, the output holding register with valid/ready, data and keep.
- Lane buffer, counter and flush logic stay in the top.

Test Plan:
1. MSB_FIRST=1, out_ready=1, beats 0x12,0x34,0x56,0x78 on 4 consecutive edges -> out_valid=1 after the 4th edge, out_data=0x12345678, out_keep=4'b1111, cnt=0.
2. MSB_FIRST=0, same beats -> out_data=0x78563412, keep=1111. Then immediately 0xAA,0xBB,0xCC,0xDD -> second word 0xDDCCBBAA with no idle cycle.
3. Backpressure: word 1 complete with out_ready=0, three more beats accepted, 4th beat -> in_ready=0 and word 1 held stable. out_ready=1 -> word 1 consumed and the 4th beat accepted at the same edge, giving word 2 out_valid next.
4. Flush partial, MSB_FIRST=1: beats 0x12,0x34 then flush=1 -> out_data=0x12340000, keep=1100, flush_done pulse. With MSB_FIRST=0 -> 0x00003412, keep=0011.
5. Flush on empty buffer -> flush_done pulse, out_valid stays 0. Flush in the same cycle as the 4th beat -> one full word with keep=1111 plus flush_done.
6. Reset mid-word: 2 beats accepted, rst=0 for half a cycle -> all outputs 0. Next 4 beats 0x01..0x04 -> 0x01020304 with no stale lanes.
